// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer: victim select, dirty writeback, line fill, install, LRU update.
// Also arbitrates the single LRU update port between installs and lookup hit touches.
module dcache_miss_ctrl #(
  parameter int NUM_SET  = 4,
  parameter int NUM_WAYS = 4,
  parameter int SET_W    = 2,
  parameter int WAY_W    = 2,
  parameter int TAG_W    = 26,
  parameter int LINE_W   = 128
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   miss_req,
  input  logic [SET_W-1:0]       miss_set,
  input  logic [TAG_W-1:0]       miss_tag,
  output logic                   miss_ready,
  output logic                   miss_done,
  output logic [WAY_W-1:0]       miss_done_way,
  input  logic                   hit_valid,
  input  logic [SET_W-1:0]       hit_set,
  input  logic [WAY_W-1:0]       hit_way,
  output logic                   lru_victim_req,
  output logic [SET_W-1:0]       lru_victim_set,
  input  logic [WAY_W-1:0]       lru_victim_way,
  input  logic                   victim_valid,
  input  logic                   victim_dirty,
  input  logic [TAG_W-1:0]       victim_tag,
  input  logic [LINE_W-1:0]      victim_line,
  output logic                   lru_update_req,
  output logic [SET_W-1:0]       lru_update_set,
  output logic [WAY_W-1:0]       lru_update_way,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_is_wr,
  output logic [TAG_W+SET_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0]      mem_req_data,
  input  logic                   mem_rsp_valid,
  input  logic [LINE_W-1:0]      mem_rsp_data,
  output logic                   fill_we,
  output logic [SET_W-1:0]       fill_set,
  output logic [WAY_W-1:0]       fill_way,
  output logic [TAG_W-1:0]       fill_tag,
  output logic [LINE_W-1:0]      fill_data
);

  if (NUM_SET != (1 << SET_W) || NUM_WAYS != (1 << WAY_W)) begin : g_param_check
    $error("dcache_miss_ctrl: NUM_SET/NUM_WAYS inconsistent with SET_W/WAY_W");
  end

  typedef enum logic [2:0] {
    IDLE, VICTIM, WB_REQ, FILL_REQ, FILL_WAIT, INSTALL, DONE
  } state_t;

  state_t             state;
  logic [SET_W-1:0]   set_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WAY_W-1:0]   way_q;

  logic               pend_valid;
  logic [SET_W-1:0]   pend_set;
  logic [WAY_W-1:0]   pend_way;
  logic               pend_load;

  // Outputs are registered on the transition into each state, so every
  // strobe is high for exactly the cycles the FSM spends in that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      set_q          <= '0;
      tag_q          <= '0;
      way_q          <= '0;
      miss_ready     <= 1'b1;
      miss_done      <= 1'b0;
      miss_done_way  <= '0;
      lru_victim_req <= 1'b0;
      lru_victim_set <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_is_wr  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      fill_we        <= 1'b0;
      fill_set       <= '0;
      fill_way       <= '0;
      fill_tag       <= '0;
      fill_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            set_q          <= miss_set;
            tag_q          <= miss_tag;
            miss_ready     <= 1'b0;
            lru_victim_req <= 1'b1;
            lru_victim_set <= miss_set;
            state          <= VICTIM;
          end
        end
        VICTIM: begin
          lru_victim_req <= 1'b0;
          way_q          <= lru_victim_way;
          mem_req_valid  <= 1'b1;
          if (victim_valid && victim_dirty) begin
            mem_req_is_wr <= 1'b1;
            mem_req_addr  <= {victim_tag, set_q};
            mem_req_data  <= victim_line;
            state         <= WB_REQ;
          end else begin
            mem_req_is_wr <= 1'b0;
            mem_req_addr  <= {tag_q, set_q};
            mem_req_data  <= '0;
            state         <= FILL_REQ;
          end
        end
        WB_REQ: begin
          // mem_req_valid stays high straight into the fill read
          if (mem_req_ready) begin
            mem_req_is_wr <= 1'b0;
            mem_req_addr  <= {tag_q, set_q};
            mem_req_data  <= '0;
            state         <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_rsp_valid) begin
            fill_we   <= 1'b1;
            fill_set  <= set_q;
            fill_way  <= way_q;
            fill_tag  <= tag_q;
            fill_data <= mem_rsp_data;
            state     <= INSTALL;
          end
        end
        INSTALL: begin
          fill_we       <= 1'b0;
          miss_done     <= 1'b1;
          miss_done_way <= way_q;
          state         <= DONE;
        end
        DONE: begin
          miss_done  <= 1'b0;
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // LRU port: install beats a parked touch, which beats a live hit.
  always_comb begin
    lru_update_req = 1'b0;
    lru_update_set = '0;
    lru_update_way = '0;
    if (fill_we) begin
      lru_update_req = 1'b1;
      lru_update_set = fill_set;
      lru_update_way = fill_way;
    end else if (pend_valid) begin
      lru_update_req = 1'b1;
      lru_update_set = pend_set;
      lru_update_way = pend_way;
    end else if (hit_valid) begin
      lru_update_req = 1'b1;
      lru_update_set = hit_set;
      lru_update_way = hit_way;
    end
    pend_load = hit_valid && (fill_we || pend_valid);
  end

  // A parked touch frees its slot in the cycle it issues, so it may reload then.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_set   <= '0;
      pend_way   <= '0;
    end else if (pend_load) begin
      pend_valid <= 1'b1;
      pend_set   <= hit_set;
      pend_way   <= hit_way;
    end else if (!fill_we) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: expected memory requests, installs, completions and
// LRU updates are queued by the driver/reference model and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_dcache_miss_ctrl;
  localparam int SET_W  = 2;
  localparam int WAY_W  = 2;
  localparam int TAG_W  = 26;
  localparam int LINE_W = 128;
  localparam int NS     = 4;
  localparam int NW     = 4;

  typedef logic [159:0] v_t;
  typedef struct packed { logic is_wr; logic [TAG_W+SET_W-1:0] addr; logic [LINE_W-1:0] data; } mem_t;
  typedef struct packed { logic [SET_W-1:0] set; logic [WAY_W-1:0] way; logic [TAG_W-1:0] tag; logic [LINE_W-1:0] data; } fill_t;
  typedef struct packed { logic [SET_W-1:0] set; logic [WAY_W-1:0] way; } upd_t;

  logic clock, reset;
  logic miss_req, miss_ready, miss_done;
  logic [SET_W-1:0] miss_set;
  logic [TAG_W-1:0] miss_tag;
  logic [WAY_W-1:0] miss_done_way;
  logic hit_valid;
  logic [SET_W-1:0] hit_set;
  logic [WAY_W-1:0] hit_way;
  logic lru_victim_req;
  logic [SET_W-1:0] lru_victim_set;
  logic [WAY_W-1:0] lru_victim_way;
  logic victim_valid, victim_dirty;
  logic [TAG_W-1:0] victim_tag;
  logic [LINE_W-1:0] victim_line;
  logic lru_update_req;
  logic [SET_W-1:0] lru_update_set;
  logic [WAY_W-1:0] lru_update_way;
  logic mem_req_valid, mem_req_ready, mem_req_is_wr;
  logic [TAG_W+SET_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_data;
  logic fill_we;
  logic [SET_W-1:0] fill_set;
  logic [WAY_W-1:0] fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic [LINE_W-1:0] fill_data;

  dcache_miss_ctrl #(
    .NUM_SET(NS), .NUM_WAYS(NW), .SET_W(SET_W), .WAY_W(WAY_W), .TAG_W(TAG_W), .LINE_W(LINE_W)
  ) dut (
    .clock(clock), .reset(reset),
    .miss_req(miss_req), .miss_set(miss_set), .miss_tag(miss_tag), .miss_ready(miss_ready),
    .miss_done(miss_done), .miss_done_way(miss_done_way),
    .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way),
    .lru_victim_req(lru_victim_req), .lru_victim_set(lru_victim_set), .lru_victim_way(lru_victim_way),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line),
    .lru_update_req(lru_update_req), .lru_update_set(lru_update_set), .lru_update_way(lru_update_way),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_is_wr(mem_req_is_wr),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .fill_we(fill_we), .fill_set(fill_set), .fill_way(fill_way), .fill_tag(fill_tag), .fill_data(fill_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Array and LRU model answering the victim query combinationally
  logic [WAY_W-1:0]  vict      [NS];
  logic              arr_valid [NS][NW];
  logic              arr_dirty [NS][NW];
  logic [TAG_W-1:0]  arr_tag   [NS][NW];
  logic [LINE_W-1:0] arr_line  [NS][NW];
  assign lru_victim_way = vict[lru_victim_set];
  assign victim_valid   = arr_valid[lru_victim_set][lru_victim_way];
  assign victim_dirty   = arr_dirty[lru_victim_set][lru_victim_way];
  assign victim_tag     = arr_tag[lru_victim_set][lru_victim_way];
  assign victim_line    = arr_line[lru_victim_set][lru_victim_way];

  mem_t  exp_mem[$];
  fill_t exp_fill[$];
  logic [WAY_W-1:0] exp_done[$];
  upd_t  exp_lru[$];
  upd_t  touch_q[$];
  upd_t  inst_upd;
  logic [SET_W-1:0] cur_set;
  int cyc, inst_cyc;
  bit rand_hits, rand_rdy;
  int total, bad;

  task automatic chk(input string nm, input v_t act, input v_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference for the LRU port: one update per cycle, install first, then the
  // oldest waiting touch, and a live hit only when nothing else is waiting.
  initial begin
    upd_t h;
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
      #2;
      h = '{hit_set, hit_way};
      if (cyc == inst_cyc) begin
        exp_lru.push_back(inst_upd);
        if (hit_valid) touch_q.push_back(h);
      end else if (touch_q.size() != 0) begin
        exp_lru.push_back(touch_q.pop_front());
        if (hit_valid) touch_q.push_back(h);
      end else if (hit_valid) begin
        exp_lru.push_back(h);
      end
      if (reset) touch_q.delete();
    end
  end

  // Monitor
  initial begin
    upd_t u; mem_t m; fill_t f; logic [WAY_W-1:0] w;
    forever begin
      @(negedge clock);
      if (lru_victim_req) chk("victim_set", v_t'(lru_victim_set), v_t'(cur_set));
      if (lru_update_req) begin
        if (exp_lru.size() == 0) chk("lru_unexpected", v_t'(lru_update_req), v_t'(0));
        else begin
          u = exp_lru.pop_front();
          chk("lru_set", v_t'(lru_update_set), v_t'(u.set));
          chk("lru_way", v_t'(lru_update_way), v_t'(u.way));
        end
      end
      if (mem_req_valid) begin
        if (exp_mem.size() == 0) chk("mem_unexpected", v_t'(mem_req_valid), v_t'(0));
        else begin
          m = exp_mem[0];
          chk("mem_is_wr", v_t'(mem_req_is_wr), v_t'(m.is_wr));
          chk("mem_addr", v_t'(mem_req_addr), v_t'(m.addr));
          if (m.is_wr) chk("mem_data", v_t'(mem_req_data), v_t'(m.data));
          if (mem_req_ready) void'(exp_mem.pop_front());
        end
      end
      if (fill_we) begin
        if (exp_fill.size() == 0) chk("fill_unexpected", v_t'(fill_we), v_t'(0));
        else begin
          f = exp_fill.pop_front();
          chk("fill_set", v_t'(fill_set), v_t'(f.set));
          chk("fill_way", v_t'(fill_way), v_t'(f.way));
          chk("fill_tag", v_t'(fill_tag), v_t'(f.tag));
          chk("fill_data", v_t'(fill_data), v_t'(f.data));
        end
      end
      if (miss_done) begin
        if (exp_done.size() == 0) chk("done_unexpected", v_t'(miss_done), v_t'(0));
        else begin
          w = exp_done.pop_front();
          chk("done_way", v_t'(miss_done_way), v_t'(w));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    miss_req      = 1'b0;
    mem_rsp_valid = 1'b0;
    if (rand_hits && !(cyc == inst_cyc && touch_q.size() != 0)) begin
      hit_valid = ($urandom_range(0, 2) == 0);
      hit_set   = SET_W'($urandom());
      hit_way   = WAY_W'($urandom());
    end else begin
      hit_valid = 1'b0;
    end
  endtask

  // mode: 0 plain, 1 hits on INSTALL and DONE, 2 miss_req during FILL_WAIT, 3 reset in FILL_WAIT
  task automatic run_miss(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t, input logic [WAY_W-1:0] vw,
                          input logic vv, input logic vd, input logic [TAG_W-1:0] vt, input logic [LINE_W-1:0] vl,
                          input int unsigned hold, input int unsigned dly, input int unsigned mode);
    logic [LINE_W-1:0] rd;
    int unsigned hcnt;
    int fill_cyc;
    bit fill_hs, rsp_sent, finished;
    rd = {$urandom(), $urandom(), $urandom(), $urandom()};
    vict[s] = vw;
    arr_valid[s][vw] = vv; arr_dirty[s][vw] = vd; arr_tag[s][vw] = vt; arr_line[s][vw] = vl;
    cur_set = s;
    chk("accept_ready", v_t'(miss_ready), v_t'(1));
    if (vv && vd) exp_mem.push_back('{1'b1, {vt, s}, vl});
    exp_mem.push_back('{1'b0, {t, s}, LINE_W'(0)});
    exp_fill.push_back('{s, vw, t, rd});
    exp_done.push_back(vw);
    inst_upd = '{s, vw};
    miss_req = 1'b1; miss_set = s; miss_tag = t;
    hcnt = 0; fill_cyc = 0; fill_hs = 0; rsp_sent = 0; finished = 0;
    for (int n = 0; n < 400 && !finished; n++) begin
      tick();
      if (miss_done) begin
        chk("done_ready", v_t'(miss_ready), v_t'(0));
        if (mode == 1) begin hit_valid = 1'b1; hit_set = 2'd0; hit_way = 2'd2; end
        tick();
        chk("ready_after_done", v_t'(miss_ready), v_t'(1));
        finished = 1;
      end else begin
        chk("busy_ready", v_t'(miss_ready), v_t'(0));
        if (mode == 1 && cyc == inst_cyc) begin hit_valid = 1'b1; hit_set = 2'd1; hit_way = 2'd0; end
        if (rand_rdy) mem_req_ready = ($urandom_range(0, 1) == 1);
        else          mem_req_ready = mem_req_valid && (hcnt >= hold);
        if (mem_req_valid) hcnt++;
        if (mem_req_valid && mem_req_ready) begin
          hcnt = 0;
          if (!mem_req_is_wr) begin fill_hs = 1; fill_cyc = cyc; end
        end else if (fill_hs && !rsp_sent && cyc > fill_cyc) begin
          if (mode == 2 && cyc == fill_cyc + 1) begin miss_req = 1'b1; miss_set = ~s; miss_tag = ~t; end
          if (mode == 3) begin
            reset = 1'b1;
            exp_fill.delete(); exp_done.delete(); inst_cyc = -1;
            tick();
            reset = 1'b0;
            chk("abort_ready", v_t'(miss_ready), v_t'(1));
            chk("abort_fill_we", v_t'(fill_we), v_t'(0));
            chk("abort_done", v_t'(miss_done), v_t'(0));
            chk("abort_mem_valid", v_t'(mem_req_valid), v_t'(0));
            repeat (3) tick();
            finished = 1;
          end else if (cyc >= fill_cyc + 1 + int'(dly)) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = rd; rsp_sent = 1; inst_cyc = cyc + 1;
          end
        end
      end
    end
    if (!finished) chk("miss_timeout", v_t'(finished), v_t'(1));
  endtask

  initial begin
    total = 0; bad = 0; inst_cyc = -1; rand_hits = 0; rand_rdy = 0;
    reset = 1'b1; miss_req = 0; miss_set = '0; miss_tag = '0;
    hit_valid = 0; hit_set = '0; hit_way = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; cur_set = '0;
    for (int s = 0; s < NS; s++) begin
      vict[s] = '0;
      for (int w = 0; w < NW; w++) begin
        arr_valid[s][w] = 0; arr_dirty[s][w] = 0; arr_tag[s][w] = '0; arr_line[s][w] = '0;
      end
    end
    repeat (3) tick();
    chk("rst_miss_ready", v_t'(miss_ready), v_t'(1));
    chk("rst_mem_valid", v_t'(mem_req_valid), v_t'(0));
    chk("rst_fill_we", v_t'(fill_we), v_t'(0));
    chk("rst_miss_done", v_t'(miss_done), v_t'(0));
    chk("rst_victim_req", v_t'(lru_victim_req), v_t'(0));
    chk("rst_lru_req", v_t'(lru_update_req), v_t'(0));
    chk("rst_mem_addr", v_t'(mem_req_addr), v_t'(0));
    chk("rst_fill_data", v_t'(fill_data), v_t'(0));
    reset = 1'b0;
    tick();

    run_miss(2'd2, 26'h1234, 2'd3, 1'b0, 1'b0, 26'h0, '0, 0, 2, 0);
    run_miss(2'd1, 26'h3C5, 2'd0, 1'b1, 1'b1, 26'h0AB, {4{32'hDEADBEEF}}, 3, 1, 0);
    run_miss(2'd1, 26'h77, 2'd2, 1'b1, 1'b0, 26'h55, {4{32'h12345678}}, 0, 1, 1);
    repeat (3) tick();

    // stray fill response while idle must be ignored
    mem_rsp_valid = 1'b1; mem_rsp_data = '1;
    tick();
    chk("stray_rsp_ready", v_t'(miss_ready), v_t'(1));
    chk("stray_rsp_fill_we", v_t'(fill_we), v_t'(0));
    tick();
    run_miss(2'd0, 26'h2A5A5A5, 2'd1, 1'b1, 1'b1, 26'h111, {4{32'hCAFEF00D}}, 1, 3, 2);
    run_miss(2'd3, 26'h0F0F0F, 2'd2, 1'b0, 1'b1, 26'h0, '0, 0, 4, 3);
    run_miss(2'd3, 26'h0F0F0F, 2'd2, 1'b1, 1'b1, 26'h3, {4{32'hA5A5A5A5}}, 0, 0, 0);

    rand_hits = 1; rand_rdy = 1;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      run_miss(SET_W'($urandom()), TAG_W'($urandom()), WAY_W'($urandom()),
               1'($urandom()), 1'($urandom()), TAG_W'($urandom()),
               {$urandom(), $urandom(), $urandom(), $urandom()}, 0, $urandom_range(0, 4), 0);
    end
    rand_hits = 0; rand_rdy = 0; mem_req_ready = 1'b0;
    repeat (4) tick();
    chk("drain_lru", v_t'(exp_lru.size()), v_t'(0));
    chk("drain_mem", v_t'(exp_mem.size()), v_t'(0));
    chk("drain_fill", v_t'(exp_fill.size()), v_t'(0));
    chk("drain_done", v_t'(exp_done.size()), v_t'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
